// File: rtl/fifo_sync_param_pkg.sv
// Shared FIFO definitions: operation encoding and the pointer wrap helper.
package bus_definitions;

    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        INSERT        = 2'b01,
        REMOVE        = 2'b10,
        INSERT_REMOVE = 2'b11
    } fifo_op_t;

    // Wraps explicitly at depth-1 so non-power-of-two depths work.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_regfile.sv
// 1W/1R storage array for fifo_sync_param: synchronous write, asynchronous read, no reset.
module regfile_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and almost-full/empty flags.
// Optional sticky overflow/underflow outputs when FIFO_SYNC_ERR_FLAGS_EN is defined.
module fifo_sync_param
    import bus_definitions::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 14,
    parameter int AEMPT_TH = 2,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_fifo,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_pndng,
    output logic             o_full,
    output logic             o_afull,
    output logic             o_aempty,
    output logic [CW-1:0]    o_count
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    ,
    output logic             o_ovf,
    output logic             o_udf
`endif
);

    fifo_op_t         op;
    logic             push_ok;
    logic             pop_ok;
    logic [AW-1:0]    wp_reg, wp_next;
    logic [AW-1:0]    rp_reg, rp_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] rdata;
    logic             pndng_reg, full_reg, afull_reg, aempty_reg;

    // A pop frees a slot in the same edge, so push is accepted when full only alongside a pop.
    always_comb begin
        op      = fifo_op_t'({i_pop, i_push});
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        case (op)
            INSERT:        push_ok = ~full_reg;
            REMOVE:        pop_ok  = pndng_reg;
            INSERT_REMOVE: begin
                push_ok = 1'b1;
                pop_ok  = pndng_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        wp_next    = push_ok ? AW'(next_ptr(32'(wp_reg), DEPTH)) : wp_reg;
        rp_next    = pop_ok  ? AW'(next_ptr(32'(rp_reg), DEPTH)) : rp_reg;
        count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    end

    regfile_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clk (i_clk),
        .we    (push_ok),
        .waddr (wp_reg),
        .wdata (i_data_in),
        .raddr (rp_reg),
        .rdata (rdata)
    );

    // Flags decode from next-count so they line up with o_count every cycle.
    always_ff @(posedge i_clk or posedge i_reset_fifo) begin
        if (i_reset_fifo) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
            pndng_reg    <= 1'b0;
            full_reg     <= 1'b0;
            afull_reg    <= (AFULL_TH == 0);
            aempty_reg   <= 1'b1;
        end else begin
            wp_reg     <= wp_next;
            rp_reg     <= rp_next;
            count_reg  <= count_next;
            pndng_reg  <= (count_next != '0);
            full_reg   <= (count_next == CW'(DEPTH));
            afull_reg  <= (count_next >= CW'(AFULL_TH));
            aempty_reg <= (count_next <= CW'(AEMPT_TH));
            if (pop_ok) begin
                data_out_reg <= rdata;
            end
        end
    end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic ovf_reg, udf_reg;

    always_ff @(posedge i_clk or posedge i_reset_fifo) begin
        if (i_reset_fifo) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_reg | (i_push & ~push_ok);
            udf_reg <= udf_reg | (i_pop & ~pop_ok);
        end
    end

    assign o_ovf = ovf_reg;
    assign o_udf = udf_reg;
`endif

    assign o_data_out = data_out_reg;
    assign o_pndng    = pndng_reg;
    assign o_full     = full_reg;
    assign o_afull    = afull_reg;
    assign o_aempty   = aempty_reg;
    assign o_count    = count_reg;

endmodule
